// File: rtl/des128_pkg.sv
// Shared constants, FSM state type and per-round shift table for the
// 128-bit expanded DES decryption key schedule.
package des128_pkg;

   localparam int unsigned HALF_W      = 56;
   localparam int unsigned ROUNDS      = 16;
   localparam int unsigned TOTAL_SHIFT = 28;
   localparam int unsigned ROUND_W     = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Encryption left-shift amount for round 1..16; the decrypt side undoes it.
   function automatic logic [1:0] sh_amt(input logic [ROUND_W-1:0] round);
      case (round)
         5'd1, 5'd2, 5'd9, 5'd16: sh_amt = 2'd1;
         default:                 sh_amt = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/des128_rotr_sel.sv
// Rotate a key half right by one or two bit positions.
module des128_rotr_sel #(
   parameter int unsigned HALF_W = 56
) (
   input  logic [HALF_W-1:0] din,
   input  logic              by2,
   output logic [HALF_W-1:0] dout
);

   always_comb begin
      if (by2) begin
         dout = {din[1:0], din[HALF_W-1:2]};
      end else begin
         dout = {din[0], din[HALF_W-1:1]};
      end
   end

endmodule

// File: rtl/des128_dec_key_sched.sv
// Decryption round-key sequencer: emits C/D halves for rounds 16 down to 1
// by right-rotating the fully shifted load value one round at a time.
module des128_dec_key_sched
   import des128_pkg::*;
#(
   parameter int unsigned P_HALF_W      = HALF_W,
   parameter int unsigned P_ROUNDS      = ROUNDS,
   parameter int unsigned P_TOTAL_SHIFT = TOTAL_SHIFT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [P_HALF_W-1:0] c_in,
   input  logic [P_HALF_W-1:0] d_in,
   output logic                key_valid,
   input  logic                key_ready,
   output logic [P_HALF_W-1:0] key_c,
   output logic [P_HALF_W-1:0] key_d,
   output logic [ROUND_W-1:0]  key_round,
   output logic                key_last
);

   state_t               state_q;
   state_t               state_d;
   logic [P_HALF_W-1:0]  c_q;
   logic [P_HALF_W-1:0]  d_q;
   logic [ROUND_W-1:0]   round_q;
   logic [P_HALF_W-1:0]  c_rot;
   logic [P_HALF_W-1:0]  d_rot;
   logic [P_HALF_W-1:0]  c_load;
   logic [P_HALF_W-1:0]  d_load;
   logic                 load_fire;
   logic                 key_fire;
   logic                 round_one;
   logic                 rot_by2;

   // Round-16 key is the total left rotation, which is fixed wiring.
   assign c_load = {c_in[P_HALF_W-P_TOTAL_SHIFT-1:0], c_in[P_HALF_W-1:P_HALF_W-P_TOTAL_SHIFT]};
   assign d_load = {d_in[P_HALF_W-P_TOTAL_SHIFT-1:0], d_in[P_HALF_W-1:P_HALF_W-P_TOTAL_SHIFT]};

   assign load_ready = (state_q == ST_IDLE) && !rst;
   assign key_valid  = (state_q == ST_EMIT);
   assign round_one  = (round_q == ROUND_W'(1));
   assign key_last   = key_valid && round_one;
   assign load_fire  = load_valid && load_ready;
   assign key_fire   = key_valid && key_ready;
   assign rot_by2    = (sh_amt(round_q) == 2'd2);

   assign key_c     = c_q;
   assign key_d     = d_q;
   assign key_round = round_q;

   des128_rotr_sel #(.HALF_W(P_HALF_W)) u_rot_c (
      .din  (c_q),
      .by2  (rot_by2),
      .dout (c_rot)
   );

   des128_rotr_sel #(.HALF_W(P_HALF_W)) u_rot_d (
      .din  (d_q),
      .by2  (rot_by2),
      .dout (d_rot)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (load_fire)             state_d = ST_EMIT;
         ST_EMIT: if (key_fire && round_one) state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Halves and round hold after the round-1 handshake so IDLE shows the last key.
   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
      end else if (load_fire) begin
         c_q     <= c_load;
         d_q     <= d_load;
         round_q <= ROUND_W'(P_ROUNDS);
      end else if (key_fire && !round_one) begin
         c_q     <= c_rot;
         d_q     <= d_rot;
         round_q <= round_q - ROUND_W'(1);
      end
   end

endmodule
